handshake_const_sink_checker: RTL and testbench
===============================================

Name: handshake_const_sink_checker

Overview:
Receiving end of a constant-producing data channel. It accepts data tokens on a valid/ready input channel and buffers them in a 2-entry FIFO. For each token it emits one dataless control token on a valid/ready output channel. As each token leaves, it is checked against an expected constant; a sticky mismatch flag and a saturating token counter record the results. It sits downstream of handshake constant units, converting data tokens back to control tokens while self-checking the constant value.

Parameters:
DATA_WIDTH, 32, width of input data channel
CHECK_WIDTH, 19, number of LSBs of ins compared; bits above are ignored; 1 <= CHECK_WIDTH <= DATA_WIDTH
EXPECTED, 19'h35562 (19'b0110101010101100010), expected value of ins[CHECK_WIDTH-1:0]
CNT_WIDTH, 16, width of token counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
ins  input  DATA_WIDTH  input data token
ins_valid  input  1  input token valid
ins_ready  output  1  block can accept a token this cycle
outs_valid  output  1  control token available
outs_ready  input  1  downstream accepts control token
mismatch  output  1  sticky: some dequeued token had ins[CHECK_WIDTH-1:0] != EXPECTED
token_count  output  CNT_WIDTH  number of control tokens delivered, saturating

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge.
- Storage: 2-entry FIFO holding ins[CHECK_WIDTH-1:0] per entry. State is occupancy 0/1/2, head and tail pointers (wrap modulo 2), and the entries.
- ins_ready = (occupancy != 2), decoded from registered state only; no combinational path from outs_ready to ins_ready.
- outs_valid = (occupancy != 0), decoded from registered state only.
- Enqueue when ins_valid && ins_ready: write the entry at tail, advance tail.
- Dequeue when outs_valid && outs_ready: compare the head entry to EXPECTED[CHECK_WIDTH-1:0], advance head.
- Occupancy update: +1 on enqueue only, -1 on dequeue only, unchanged on both.
- Simultaneous enqueue and dequeue at occupancy 1 keeps occupancy 1, giving throughput of 1 token/cycle.
- At occupancy 2, ins_ready=0, so no enqueue is possible; a dequeue returns occupancy to 1.
- At occupancy 0, no dequeue is possible, since outs_valid=0.
- Latency: a token accepted at edge N raises outs_valid in cycle N+1. There is no combinational bypass.
- mismatch: set on the edge where a dequeued head mismatches. It stays set until rst and is never cleared by traffic.
- token_count: +1 per dequeue. It holds at 2^CNT_WIDTH-1 (saturates, no wrap).
- Valid/ready rules:
  - Once outs_valid rises, it stays high until consumed.
  - Upstream ins_valid/ins content is not required to hold, but only transfers with ins_ready=1 are accepted.
- Reset values:
  - occupancy=0, pointers=0, mismatch=0, token_count=0.
  - outs_valid=0.
  - ins_ready=0 while rst is high. ins_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: buffered tokens are discarded without being checked or counted. Any handshake coinciding with a rst edge has no effect.
- Entry contents are don't-care at reset; no output depends on them while occupancy=0.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> ins_ready=1, outs_valid=0, mismatch=0, token_count=0.
- Single token: ins=32'h00035562, ins_valid for 1 cycle, outs_ready=1 -> outs_valid high exactly 1 cycle (the next cycle), token_count=1, mismatch=0.
- Backpressure: outs_ready=0, present 3 tokens back-to-back.
  - 2 are accepted; ins_ready=0 after the 2nd.
  - Raise outs_ready -> 3rd accepted the cycle after the first dequeue; 3 control tokens delivered, token_count=3.
- Streaming: 100 tokens with ins_valid=1 and outs_ready=1 continuously -> 1 token/cycle after 1-cycle fill, token_count=100.
- Mismatch and upper bits:
  - Token 32'hFFF35562 -> no mismatch (upper bits ignored).
  - Then token 32'h00035563 -> mismatch=1 on its dequeue edge, staying 1 after 10 further correct tokens.
- Counter and reset: with CNT_WIDTH=4, send 20 tokens -> token_count saturates at 15. Then assert rst with 2 tokens buffered -> occupancy 0, token_count=0, mismatch=0, no extra outs_valid.

Source files
------------

// File: rtl/handshake_const_sink_checker.sv
// handshake_const_sink_checker: data-to-control token sink with constant self-check
// Accepts data tokens into a 2-entry FIFO and emits one dataless control token per entry.
// Each token is compared against EXPECTED as it leaves the FIFO.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   ins, ins_valid    - input data channel
//   ins_ready         - input channel can accept a token
//   outs_valid        - output control channel has a token
//   outs_ready        - downstream accepts the control token
//   mismatch          - sticky flag: a dequeued token differed from EXPECTED
//   token_count       - saturating count of delivered control tokens
module handshake_const_sink_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int CHECK_WIDTH = 19,
  parameter logic [CHECK_WIDTH-1:0] EXPECTED = 19'h35562,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  token_count
);
  logic [1:0] occ_q, occ_d;
  logic head_q, tail_q;
  logic [CHECK_WIDTH-1:0] mem_q [2];
  logic mismatch_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic enq, deq;
  // ready depends only on registered occupancy (and rst), never on outs_ready
  assign ins_ready = !rst && (occ_q != 2'd2);
  assign outs_valid = occ_q != 2'd0;
  assign enq = ins_valid && ins_ready;
  assign deq = outs_valid && outs_ready;
  assign mismatch = mismatch_q;
  assign token_count = cnt_q;
  always_comb occ_d = occ_q + {1'b0, enq} - {1'b0, deq};
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      mismatch_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (enq) begin
        mem_q[tail_q] <= ins[CHECK_WIDTH-1:0];
        tail_q <= ~tail_q;
      end
      if (deq) begin
        head_q <= ~head_q;
        if (mem_q[head_q] != EXPECTED) mismatch_q <= 1'b1;
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_handshake_const_sink_checker.sv
// tb_handshake_const_sink_checker: scoreboard bench for handshake_const_sink_checker
module tb_handshake_const_sink_checker;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] ins;
  logic ins_valid, outs_ready;
  logic ins_ready, outs_valid, mismatch;
  logic [15:0] token_count;
  logic ins_ready4, outs_valid4, mismatch4;
  logic [3:0] token_count4;
  int checks = 0;
  int failures = 0;
  bit sb [$];
  bit m_mis;
  int m_cnt;
  always #5 clk = ~clk;
  handshake_const_sink_checker dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .mismatch(mismatch),
    .token_count(token_count)
  );
  handshake_const_sink_checker #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
    .outs_valid(outs_valid4), .outs_ready(outs_ready), .mismatch(mismatch4),
    .token_count(token_count4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_outs();
    chk("ins_ready", {31'd0, ins_ready}, {31'd0, sb.size() != 2});
    chk("outs_valid", {31'd0, outs_valid}, {31'd0, sb.size() != 0});
    chk("outs_valid4", {31'd0, outs_valid4}, {31'd0, sb.size() != 0});
    chk("mismatch", {31'd0, mismatch}, {31'd0, m_mis});
    chk("mismatch4", {31'd0, mismatch4}, {31'd0, m_mis});
    chk("token_count", {16'd0, token_count}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
    chk("token_count4", {28'd0, token_count4}, (m_cnt > 15) ? 32'd15 : m_cnt);
  endtask
  task automatic tick(input bit iv, input logic [31:0] d, input bit ordy);
    bit enq, deq, bad;
    ins_valid = iv;
    ins = d;
    outs_ready = ordy;
    enq = iv && sb.size() != 2;
    deq = ordy && sb.size() != 0;
    @(posedge clk);
    if (deq) begin
      bad = sb.pop_front();
      m_mis |= bad;
      m_cnt++;
    end
    if (enq) sb.push_back(d[18:0] != 19'h35562);
    @(negedge clk);
    check_outs();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    ins_valid = 1'b1;
    ins = 32'h0003_5563;
    outs_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ins_ready", {31'd0, ins_ready}, 32'd0);
    chk("rst_outs_valid", {31'd0, outs_valid}, 32'd0);
    chk("rst_count", {16'd0, token_count}, 32'd0);
    chk("rst_count4", {28'd0, token_count4}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    sb.delete();
    m_mis = 1'b0;
    m_cnt = 0;
    rst = 1'b0;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    #1;
    chk("post_rst_ins_ready", {31'd0, ins_ready}, 32'd1);
  endtask
  function automatic logic [31:0] good();
    logic [31:0] d;
    d = $urandom;
    d[18:0] = 19'h35562;
    return d;
  endfunction
  initial begin
    do_reset();
    tick(0, 32'h0, 1);
    tick(1, 32'h0003_5562, 1);
    chk("single_valid_next", {31'd0, outs_valid}, 32'd1);
    tick(0, 32'h0, 1);
    chk("single_count", {16'd0, token_count}, 32'd1);
    tick(0, 32'h0, 1);
    chk("single_valid_once", {31'd0, outs_valid}, 32'd0);
    do_reset();
    tick(1, good(), 0);
    tick(1, good(), 0);
    chk("bp_full", {31'd0, ins_ready}, 32'd0);
    tick(1, 32'h0003_5562, 0);
    tick(1, 32'h0003_5562, 1);
    tick(1, 32'h0003_5562, 1);
    tick(0, 32'h0, 1);
    tick(0, 32'h0, 1);
    chk("bp_count", {16'd0, token_count}, 32'd3);
    do_reset();
    repeat (100) tick(1, good(), 1);
    tick(0, 32'h0, 1);
    chk("stream_count", {16'd0, token_count}, 32'd100);
    chk("stream_sat4", {28'd0, token_count4}, 32'd15);
    repeat (200) tick($urandom_range(0, 1), good(), $urandom_range(0, 1));
    repeat (3) tick(0, 32'h0, 1);
    tick(1, 32'hFFF3_5562, 1);
    tick(0, 32'h0, 1);
    chk("upper_ignored", {31'd0, mismatch}, 32'd0);
    tick(1, 32'h0003_5563, 1);
    tick(0, 32'h0, 1);
    chk("mismatch_set", {31'd0, mismatch}, 32'd1);
    repeat (10) tick(1, good(), 1);
    tick(0, 32'h0, 1);
    chk("mismatch_sticky", {31'd0, mismatch}, 32'd1);
    do_reset();
    repeat (20) tick(1, good(), 1);
    tick(0, 32'h0, 1);
    chk("sat4_20", {28'd0, token_count4}, 32'd15);
    tick(1, good(), 0);
    tick(1, good(), 0);
    do_reset();
    repeat (3) tick(0, 32'h0, 1);
    chk("flush_count", {16'd0, token_count}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
